am2950_fifo_port: RTL and testbench

//  Parametrised successor of the am2950 bidirectional I/O port: the single R/S registers become

---
 rtl/am2950_fifo_port_if.sv | 33 +++
 rtl/am2950_fifo_port.sv | 85 ++++++++
 tb/tb_am2950_fifo_port.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/am2950_fifo_port_if.sv
// Control and status bundle for the am2950 FIFO port. The A/B data pads stay outside as inout nets.
interface am2950_fifo_port_if #(
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic          cer_;
  logic          ces_;
  logic          oea_;
  logic          oeb_;
  logic          ackr;
  logic          acks;
  logic          clrr;
  logic          clrs;
  logic          fr;
  logic          fs;
  logic          fullr;
  logic          fulls;
  logic [AW:0]   cntr;
  logic [AW:0]   cnts;
  logic          ovr;
  logic          ovs;

  modport slave (
    input  cer_, ces_, oea_, oeb_, ackr, acks, clrr, clrs,
    output fr, fs, fullr, fulls, cntr, cnts, ovr, ovs
  );

  modport master (
    output cer_, ces_, oea_, oeb_, ackr, acks, clrr, clrs,
    input  fr, fs, fullr, fulls, cntr, cnts, ovr, ovs
  );
endinterface

// File: rtl/am2950_fifo_port.sv
// Buffered bidirectional mailbox: R queue carries A->B, S queue carries B->A.
// Both queues share one implementation, instantiated per direction (index 0 = R, 1 = S).
module am2950_fifo_port #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  inout  wire  [WIDTH-1:0] a,
  inout  wire  [WIDTH-1:0] b,
  am2950_fifo_port_if.slave bus
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [1:0]             w_push;
  logic [1:0]             w_pop;
  logic [1:0]             w_flush;
  logic [1:0][WIDTH-1:0]  w_din;
  logic [1:0][WIDTH-1:0]  w_head;
  logic [1:0][AW:0]       w_cnt;
  logic [1:0]             w_ov;
  logic [1:0]             w_nonempty;

  assign w_push  = {~bus.ces_, ~bus.cer_};
  assign w_pop   = {bus.acks, bus.ackr};
  assign w_flush = {bus.clrs, bus.clrr};
  // Pushes sample the pads, so a queue head driven onto a can loop back into R.
  assign w_din   = {b, a};

  for (genvar q = 0; q < 2; q++) begin : g_queue
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_cnt;
    logic             r_ov;
    logic             w_full;
    logic             w_empty;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_full    = (r_cnt == CNT_FULL);
    assign w_empty   = (r_cnt == '0);
    assign w_do_pop  = w_pop[q] && !w_empty;
    // A pop in the same cycle frees the slot a full-queue push needs.
    assign w_do_push = w_push[q] && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
      if (clr || w_flush[q]) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
        r_ov  <= 1'b0;
      end else begin
        if (w_do_push) r_wp <= r_wp + 1'b1;
        if (w_do_pop)  r_rp <= r_rp + 1'b1;
        if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + 1'b1;
        else if (w_do_pop && !w_do_push) r_cnt <= r_cnt - 1'b1;
        if (w_push[q] && w_full && !w_pop[q]) r_ov <= 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wp] <= w_din[q];
    end

    assign w_head[q]     = r_mem[r_rp];
    assign w_cnt[q]      = r_cnt;
    assign w_ov[q]       = r_ov;
    assign w_nonempty[q] = !w_empty;
  end

  assign bus.fr    = w_nonempty[0];
  assign bus.fs    = w_nonempty[1];
  assign bus.fullr = (w_cnt[0] == CNT_FULL);
  assign bus.fulls = (w_cnt[1] == CNT_FULL);
  assign bus.cntr  = w_cnt[0];
  assign bus.cnts  = w_cnt[1];
  assign bus.ovr   = w_ov[0];
  assign bus.ovs   = w_ov[1];

  // An empty queue presents zeros rather than stale storage.
  assign b = bus.oeb_ ? {WIDTH{1'bz}} : (w_nonempty[0] ? w_head[0] : '0);
  assign a = bus.oea_ ? {WIDTH{1'bz}} : (w_nonempty[1] ? w_head[1] : '0);
endmodule

// File: tb/tb_am2950_fifo_port.sv
// Scenario bench for am2950_fifo_port with a queue-based reference model per direction.
module tb_am2950_fifo_port;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             clr;
  wire  [WIDTH-1:0] a;
  wire  [WIDTH-1:0] b;
  logic [WIDTH-1:0] a_drv;
  logic [WIDTH-1:0] b_drv;
  logic             a_en;
  logic             b_en;
  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] mr[$];
  logic [WIDTH-1:0] ms[$];
  bit               m_ovr;
  bit               m_ovs;

  always #5 clk = ~clk;

  assign a = a_en ? a_drv : {WIDTH{1'bz}};
  assign b = b_en ? b_drv : {WIDTH{1'bz}};

  am2950_fifo_port_if #(.DEPTH(DEPTH)) bus ();

  am2950_fifo_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .clr (clr),
    .a   (a),
    .b   (b),
    .bus (bus.slave)
  );

  function automatic logic [WIDTH-1:0] head_r();
    return (mr.size() != 0) ? mr[0] : '0;
  endfunction

  function automatic logic [WIDTH-1:0] head_s();
    return (ms.size() != 0) ? ms[0] : '0;
  endfunction

  // One clock edge of stimulus; the model advances with the same inputs.
  task automatic apply(input bit rst, input bit pr, input logic [WIDTH-1:0] dr,
                       input bit ps, input logic [WIDTH-1:0] ds,
                       input bit kr, input bit ks, input bit flr, input bit fls);
    bit full;
    bit dpop;
    clr      = rst;
    bus.cer_ = ~pr;
    bus.ces_ = ~ps;
    bus.ackr = kr;
    bus.acks = ks;
    bus.clrr = flr;
    bus.clrs = fls;
    a_drv    = dr;
    b_drv    = ds;
    a_en     = pr && bus.oea_;
    b_en     = ps && bus.oeb_;
    @(posedge clk);
    #1;
    clr = 1'b0; bus.cer_ = 1'b1; bus.ces_ = 1'b1; bus.ackr = 1'b0; bus.acks = 1'b0;
    bus.clrr = 1'b0; bus.clrs = 1'b0; a_en = 1'b0; b_en = 1'b0;
    if (rst) begin
      mr.delete(); ms.delete(); m_ovr = 1'b0; m_ovs = 1'b0;
    end else begin
      if (flr) begin
        mr.delete(); m_ovr = 1'b0;
      end else begin
        full = (mr.size() == DEPTH);
        dpop = kr && (mr.size() != 0);
        if (pr && full && !kr) m_ovr = 1'b1;
        if (dpop) void'(mr.pop_front());
        if (pr && (!full || dpop)) mr.push_back(dr);
      end
      if (fls) begin
        ms.delete(); m_ovs = 1'b0;
      end else begin
        full = (ms.size() == DEPTH);
        dpop = ks && (ms.size() != 0);
        if (ps && full && !ks) m_ovs = 1'b1;
        if (dpop) void'(ms.pop_front());
        if (ps && (!full || dpop)) ms.push_back(ds);
      end
    end
  endtask

  task automatic test_reset();
    bus.oea_ = 1'b1; bus.oeb_ = 1'b1;
    apply(1, 0, '0, 0, '0, 0, 0, 0, 0);
    checks++; if (bus.cntr !== '0) begin errors++; $display("FAIL reset_cntr got %0d want 0", bus.cntr); end
    checks++; if (bus.cnts !== '0) begin errors++; $display("FAIL reset_cnts got %0d want 0", bus.cnts); end
    checks++; if ({bus.fr, bus.fs} !== 2'b00) begin errors++; $display("FAIL reset_flags fr/fs got %b%b want 00", bus.fr, bus.fs); end
    checks++; if ({bus.ovr, bus.ovs} !== 2'b00) begin errors++; $display("FAIL reset_ov got %b%b want 00", bus.ovr, bus.ovs); end
    checks++; if ({bus.fullr, bus.fulls} !== 2'b00) begin errors++; $display("FAIL reset_full got %b%b want 00", bus.fullr, bus.fulls); end
    // With both output enables high the pads must be released to the bench.
    a_drv = 8'h3C; b_drv = 8'hC3; a_en = 1'b1; b_en = 1'b1;
    #1;
    checks++; if (a !== 8'h3C) begin errors++; $display("FAIL reset_a_released got %h want 3c", a); end
    checks++; if (b !== 8'hC3) begin errors++; $display("FAIL reset_b_released got %h want c3", b); end
    a_en = 1'b0; b_en = 1'b0;
  endtask

  task automatic test_fill_drain_r();
    logic [WIDTH-1:0] vals [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    foreach (vals[i]) apply(0, 1, vals[i], 0, '0, 0, 0, 0, 0);
    checks++; if (bus.fullr !== 1'b1) begin errors++; $display("FAIL fill_fullr got %b want 1", bus.fullr); end
    checks++; if (bus.cntr !== 3'd4) begin errors++; $display("FAIL fill_cntr got %0d want 4", bus.cntr); end
    bus.oeb_ = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (b !== head_r()) begin errors++; $display("FAIL drain_b[%0d] got %h want %h", i, b, head_r()); end
      apply(0, 0, '0, 0, '0, 1, 0, 0, 0);
      checks++; if (bus.cntr !== (AW+1)'(mr.size())) begin errors++; $display("FAIL drain_cntr[%0d] got %0d want %0d", i, bus.cntr, mr.size()); end
    end
    checks++; if (bus.fr !== 1'b0) begin errors++; $display("FAIL drain_fr got %b want 0", bus.fr); end
    checks++; if (b !== 8'h00) begin errors++; $display("FAIL drain_b_empty got %h want 00", b); end
    apply(0, 0, '0, 0, '0, 1, 0, 0, 0);
    checks++; if ({bus.cntr, bus.ovr} !== 4'b0000) begin errors++; $display("FAIL empty_pop cntr/ovr got %0d/%b want 0/0", bus.cntr, bus.ovr); end
    apply(0, 1, 8'h42, 0, '0, 1, 0, 0, 0);
    checks++; if (bus.cntr !== 3'd1 || b !== 8'h42) begin errors++; $display("FAIL empty_push_pop cntr/b got %0d/%h want 1/42", bus.cntr, b); end
    apply(0, 0, '0, 0, '0, 0, 0, 1, 0);
    bus.oeb_ = 1'b1;
  endtask

  task automatic test_overflow_r();
    logic [WIDTH-1:0] vals [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    bus.oeb_ = 1'b0;
    foreach (vals[i]) apply(0, 1, vals[i], 0, '0, 0, 0, 0, 0);
    apply(0, 1, 8'hEE, 0, '0, 0, 0, 0, 0);
    checks++; if (bus.ovr !== 1'b1) begin errors++; $display("FAIL ovf_ovr got %b want 1", bus.ovr); end
    checks++; if (bus.cntr !== 3'd4 || b !== 8'hAA) begin errors++; $display("FAIL ovf_intact cntr/b got %0d/%h want 4/aa", bus.cntr, b); end
    apply(0, 1, 8'hFF, 0, '0, 1, 0, 0, 0);
    checks++; if (bus.cntr !== 3'd4 || bus.ovr !== 1'b1) begin errors++; $display("FAIL full_push_pop cntr/ovr got %0d/%b want 4/1", bus.cntr, bus.ovr); end
    checks++; if (b !== 8'hBB) begin errors++; $display("FAIL full_push_pop_b got %h want bb", b); end
    checks++; if (bus.ovs !== 1'b0) begin errors++; $display("FAIL ovf_ovs_independent got %b want 0", bus.ovs); end
    apply(0, 1, 8'h99, 0, '0, 1, 0, 1, 0);
    checks++; if (bus.cntr !== 3'd0 || bus.ovr !== 1'b0) begin errors++; $display("FAIL clrr cntr/ovr got %0d/%b want 0/0", bus.cntr, bus.ovr); end
    bus.oeb_ = 1'b1;
  endtask

  task automatic test_s_queue();
    bus.oea_ = 1'b0;
    #1;
    checks++; if (a !== 8'h00) begin errors++; $display("FAIL s_empty_a got %h want 00", a); end
    apply(0, 0, '0, 1, 8'hCC, 0, 0, 0, 0);
    checks++; if (a !== 8'hCC || bus.fs !== 1'b1) begin errors++; $display("FAIL s_push a/fs got %h/%b want cc/1", a, bus.fs); end
    checks++; if (bus.cnts !== 3'd1) begin errors++; $display("FAIL s_push_cnts got %0d want 1", bus.cnts); end
    apply(0, 0, '0, 0, '0, 0, 1, 0, 0);
    checks++; if (a !== 8'h00 || bus.fs !== 1'b0) begin errors++; $display("FAIL s_pop a/fs got %h/%b want 00/0", a, bus.fs); end
    bus.oea_ = 1'b1;
    apply(0, 1, 8'h77, 0, '0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) apply(0, 0, '0, 1, WIDTH'(8'h11 * (i + 1)), 0, 0, 0, 0);
    checks++; if (bus.ovs !== 1'b1 || bus.fulls !== 1'b1) begin errors++; $display("FAIL s_ovf ovs/fulls got %b/%b want 1/1", bus.ovs, bus.fulls); end
    checks++; if (bus.ovr !== 1'b0 || bus.cntr !== 3'd1) begin errors++; $display("FAIL s_ovf_r_intact ovr/cntr got %b/%0d want 0/1", bus.ovr, bus.cntr); end
    apply(0, 0, '0, 1, 8'h66, 0, 0, 0, 1);
    checks++; if (bus.cnts !== 3'd0 || bus.ovs !== 1'b0) begin errors++; $display("FAIL clrs cnts/ovs got %0d/%b want 0/0", bus.cnts, bus.ovs); end
    checks++; if (bus.cntr !== 3'd1) begin errors++; $display("FAIL clrs_r_intact cntr got %0d want 1", bus.cntr); end
    apply(0, 0, '0, 0, '0, 0, 0, 1, 0);
  endtask

  task automatic test_loopback();
    apply(0, 0, '0, 1, 8'h5A, 0, 0, 0, 0);
    bus.oea_ = 1'b0;
    apply(0, 1, 8'h5A, 0, '0, 0, 0, 0, 0);
    checks++; if (bus.cntr !== 3'd1 || bus.cnts !== 3'd1) begin errors++; $display("FAIL loop_counts cntr/cnts got %0d/%0d want 1/1", bus.cntr, bus.cnts); end
    bus.oeb_ = 1'b0;
    #1;
    checks++; if (b !== 8'h5A) begin errors++; $display("FAIL loop_b got %h want 5a", b); end
    bus.oea_ = 1'b1; bus.oeb_ = 1'b1;
    apply(0, 0, '0, 0, '0, 0, 0, 1, 1);
  endtask

  task automatic test_reset_mid();
    apply(0, 1, 8'h11, 1, 8'h44, 0, 0, 0, 0);
    apply(0, 1, 8'h22, 1, 8'h55, 0, 0, 0, 0);
    apply(0, 1, 8'h33, 0, '0, 0, 0, 0, 0);
    checks++; if (bus.cntr !== 3'd3 || bus.cnts !== 3'd2) begin errors++; $display("FAIL mid_pre cntr/cnts got %0d/%0d want 3/2", bus.cntr, bus.cnts); end
    apply(1, 1, 8'h66, 0, '0, 1, 0, 0, 0);
    checks++; if (bus.cntr !== 3'd0 || bus.cnts !== 3'd0) begin errors++; $display("FAIL mid_rst cntr/cnts got %0d/%0d want 0/0", bus.cntr, bus.cnts); end
    checks++; if ({bus.fr, bus.fs} !== 2'b00) begin errors++; $display("FAIL mid_rst fr/fs got %b%b want 00", bus.fr, bus.fs); end
  endtask

  task automatic test_back_to_back();
    logic [2*(AW+1)+5:0] got;
    logic [2*(AW+1)+5:0] exp;
    bus.oea_ = 1'b1; bus.oeb_ = 1'b1;
    for (int i = 0; i < 300; i++) begin
      apply(0, $urandom_range(0, 9) < 6, WIDTH'($urandom), $urandom_range(0, 9) < 6, WIDTH'($urandom),
            $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4,
            $urandom_range(0, 31) == 0, $urandom_range(0, 31) == 0);
      got = {bus.cntr, bus.cnts, bus.ovr, bus.ovs, bus.fullr, bus.fulls, bus.fr, bus.fs};
      exp = {(AW+1)'(mr.size()), (AW+1)'(ms.size()), m_ovr, m_ovs,
             mr.size() == DEPTH, ms.size() == DEPTH, mr.size() != 0, ms.size() != 0};
      checks++; if (got !== exp) begin errors++; $display("FAIL b2b_status[%0d] got %h want %h", i, got, exp); end
    end
    bus.oea_ = 1'b0; bus.oeb_ = 1'b0;
    #1;
    for (int i = 0; i <= DEPTH; i++) begin
      checks++; if (b !== head_r()) begin errors++; $display("FAIL b2b_drain_b[%0d] got %h want %h", i, b, head_r()); end
      checks++; if (a !== head_s()) begin errors++; $display("FAIL b2b_drain_a[%0d] got %h want %h", i, a, head_s()); end
      apply(0, 0, '0, 0, '0, 1, 1, 0, 0);
    end
    bus.oea_ = 1'b1; bus.oeb_ = 1'b1;
  endtask

  initial begin
    clr = 1'b0; a_en = 1'b0; b_en = 1'b0; a_drv = '0; b_drv = '0;
    m_ovr = 1'b0; m_ovs = 1'b0;
    bus.cer_ = 1'b1; bus.ces_ = 1'b1; bus.oea_ = 1'b1; bus.oeb_ = 1'b1;
    bus.ackr = 1'b0; bus.acks = 1'b0; bus.clrr = 1'b0; bus.clrs = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill_drain_r();
    test_overflow_r();
    test_s_queue();
    test_loopback();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
